// File: rtl/sreg194_seq_ctrl_if.sv
// Control/feedback bundle between the 194 sequencer and the register it drives.
// The sequencer takes the slave side; the environment (register model, host) takes the master side.
interface sreg194_seq_ctrl_if;
    logic       START;
    logic       STOP;
    logic       EN;
    logic [1:0] MODE;
    logic [3:0] SEED;
    logic [3:0] Q;
    logic       Clear;
    logic       S1;
    logic       S0;
    logic       Right;
    logic       Left;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       STEP;
    logic       FIX;
    logic [7:0] STEPS;
    logic       BUSY;

    modport slave (
        input  START, STOP, EN, MODE, SEED, Q,
        output Clear, S1, S0, Right, Left, A, B, C, D, STEP, FIX, STEPS, BUSY
    );

    modport master (
        output START, STOP, EN, MODE, SEED, Q,
        input  Clear, S1, S0, Right, Left, A, B, C, D, STEP, FIX, STEPS, BUSY
    );
endinterface

// File: rtl/sreg194_seq_ctrl.sv
// Sequencer for a 74LS194-style shift register: issues a one-cycle STEP enable plus mode pins,
// serial and parallel data for ring-right, ring-left and Johnson sequences with self-start reload.
module sreg194_seq_ctrl #(
    parameter int DIV = 27000000,
    parameter int CW  = 25
) (
    input  logic              exCLK,
    input  logic              RST,
    sreg194_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CLR, LOAD, RUN} state_t;

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] pre_q, pre_d;
    logic          clear_q, clear_d;
    logic [1:0]    sel_q, sel_d;
    logic          right_q, right_d;
    logic          left_q, left_d;
    logic [3:0]    par_q, par_d;
    logic          step_q, step_d;
    logic          fix_q, fix_d;
    logic [7:0]    steps_q, steps_d;
    logic          busy_q, busy_d;
    logic          tick;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic johnson_ok(input logic [3:0] v);
        case (v)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Pattern that puts the register back on a legal orbit for the selected mode.
    function automatic logic [3:0] load_value(input logic [1:0] mode, input logic [3:0] seed);
        case (mode)
            2'b00, 2'b01: return one_hot(seed) ? seed : 4'b0001;
            2'b10:        return johnson_ok(seed) ? seed : 4'b0000;
            default:      return seed;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        clear_d = 1'b1;
        sel_d   = 2'b00;
        right_d = right_q;
        left_d  = left_q;
        par_d   = par_q;
        step_d  = 1'b0;
        fix_d   = 1'b0;
        steps_d = steps_q;
        tick    = (state_q == RUN) && bus.EN && (pre_q == LAST);

        if (bus.STOP) begin
            state_d = IDLE;
            pre_d   = '0;
            right_d = 1'b0;
            left_d  = 1'b0;
            par_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    pre_d = '0;
                    if (bus.START) begin
                        state_d = CLR;
                        clear_d = 1'b0;
                        steps_d = 8'd0;
                    end
                end
                CLR: begin
                    state_d = LOAD;
                    sel_d   = 2'b11;
                    par_d   = load_value(bus.MODE, bus.SEED);
                    step_d  = 1'b1;
                    steps_d = steps_q + 8'd1;
                end
                LOAD: begin
                    state_d = RUN;
                    pre_d   = '0;
                end
                RUN: begin
                    if (bus.EN) pre_d = tick ? '0 : pre_q + CW'(1);
                    if (tick) begin
                        // Q outside the mode's legal orbit is reloaded rather than shifted.
                        case (bus.MODE)
                            2'b00: begin
                                if (one_hot(bus.Q)) begin
                                    sel_d   = 2'b01;
                                    right_d = bus.Q[3];
                                    step_d  = 1'b1;
                                end else fix_d = 1'b1;
                            end
                            2'b01: begin
                                if (one_hot(bus.Q)) begin
                                    sel_d  = 2'b10;
                                    left_d = bus.Q[0];
                                    step_d = 1'b1;
                                end else fix_d = 1'b1;
                            end
                            2'b10: begin
                                if (johnson_ok(bus.Q)) begin
                                    sel_d   = 2'b01;
                                    right_d = ~bus.Q[3];
                                    step_d  = 1'b1;
                                end else fix_d = 1'b1;
                            end
                            default: ;
                        endcase
                        if (fix_d) begin
                            sel_d  = 2'b11;
                            par_d  = load_value(bus.MODE, bus.SEED);
                            step_d = 1'b1;
                        end
                        if (step_d) steps_d = steps_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge exCLK) begin
        if (RST) begin
            state_q <= IDLE;
            pre_q   <= '0;
            clear_q <= 1'b1;
            sel_q   <= 2'b00;
            right_q <= 1'b0;
            left_q  <= 1'b0;
            par_q   <= 4'd0;
            step_q  <= 1'b0;
            fix_q   <= 1'b0;
            steps_q <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            clear_q <= clear_d;
            sel_q   <= sel_d;
            right_q <= right_d;
            left_q  <= left_d;
            par_q   <= par_d;
            step_q  <= step_d;
            fix_q   <= fix_d;
            steps_q <= steps_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Clear = clear_q;
    assign bus.S1    = sel_q[1];
    assign bus.S0    = sel_q[0];
    assign bus.Right = right_q;
    assign bus.Left  = left_q;
    assign bus.A     = par_q[0];
    assign bus.B     = par_q[1];
    assign bus.C     = par_q[2];
    assign bus.D     = par_q[3];
    assign bus.STEP  = step_q;
    assign bus.FIX   = fix_q;
    assign bus.STEPS = steps_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_sreg194_seq_ctrl.sv
// Bench for sreg194_seq_ctrl: a 194 register model closes the Q loop, a cycle reference model
// predicts every output, and directed steps follow the register sequences end to end.
module tb_sreg194_seq_ctrl;

    localparam int DIV = 4;
    localparam int CW  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ovr = 1'b0;
    logic [3:0] ovr_val = 4'd0;
    logic [3:0] q194 = 4'd0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         m_valid = 0;
    bit         m_busy  = 0;
    int         m_age   = 0;
    int         m_cnt   = 0;
    int         m_steps = 0;
    logic       e_clear = 1'b1;
    logic [1:0] e_sel   = 2'b00;
    logic       e_right = 1'b0;
    logic       e_left  = 1'b0;
    logic [3:0] e_par   = 4'd0;
    logic       e_step  = 1'b0;
    logic       e_fix   = 1'b0;
    logic       e_busy  = 1'b0;

    logic [3:0] jlist    [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [3:0] ring_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] john_exp [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    sreg194_seq_ctrl_if bus ();

    sreg194_seq_ctrl #(.DIV(DIV), .CW(CW)) dut (
        .exCLK (clk),
        .RST   (rst),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    assign bus.Q = ovr ? ovr_val : q194;

    // 74LS194 behaviour with STEP as the clock enable
    always @(posedge clk) begin
        if (!bus.Clear) q194 <= 4'd0;
        else if (bus.STEP) begin
            case ({bus.S1, bus.S0})
                2'b11:   q194 <= {bus.D, bus.C, bus.B, bus.A};
                2'b01:   q194 <= {q194[2:0], bus.Right};
                2'b10:   q194 <= {bus.Left, q194[3:1]};
                default: q194 <= q194;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_john(input logic [3:0] v);
        bit hit;
        hit = 0;
        for (int i = 0; i < 8; i++) if (jlist[i] == v) hit = 1;
        return hit;
    endfunction

    function automatic logic [3:0] ref_load(input logic [1:0] mode, input logic [3:0] seed);
        if (mode < 2'd2) return ($countones(seed) == 1) ? seed : 4'b0001;
        if (mode == 2'd2) return is_john(seed) ? seed : 4'b0000;
        return seed;
    endfunction

    // Predict the outputs that the coming clock edge should produce.
    task automatic model_update();
        bit         tick;
        bit         ok;
        logic [3:0] q;
        tick    = 0;
        ok      = 1;
        q       = bus.Q;
        e_step  = 1'b0;
        e_fix   = 1'b0;
        e_sel   = 2'b00;
        e_clear = 1'b1;
        if (rst) begin
            m_valid = 1; m_busy = 0; m_age = 0; m_cnt = 0; m_steps = 0;
            e_right = 1'b0; e_left = 1'b0; e_par = 4'd0;
        end else if (bus.STOP) begin
            m_busy = 0; m_age = 0; m_cnt = 0;
            e_right = 1'b0; e_left = 1'b0; e_par = 4'd0;
        end else if (!m_busy) begin
            if (bus.START) begin
                m_busy = 1; m_age = 1; m_steps = 0; e_clear = 1'b0;
            end
        end else begin
            if (m_age < 4) m_age++;
            if (m_age == 2) begin
                e_sel = 2'b11; e_par = ref_load(bus.MODE, bus.SEED); e_step = 1'b1;
                m_steps = (m_steps + 1) % 256;
            end else if (m_age == 3) begin
                m_cnt = 0;
            end else if (bus.EN) begin
                tick  = (m_cnt == DIV - 1);
                m_cnt = (m_cnt + 1) % DIV;
            end
            if (tick) begin
                case (bus.MODE)
                    2'd0: begin ok = ($countones(q) == 1); e_sel = 2'b01; if (ok) e_right = q[3]; end
                    2'd1: begin ok = ($countones(q) == 1); e_sel = 2'b10; if (ok) e_left = q[0]; end
                    2'd2: begin ok = is_john(q); e_sel = 2'b01; if (ok) e_right = ~q[3]; end
                    default: begin ok = 1; e_sel = 2'b00; end
                endcase
                if (!ok) begin
                    e_sel = 2'b11; e_par = ref_load(bus.MODE, bus.SEED); e_fix = 1'b1;
                end
                if (bus.MODE != 2'd3) begin
                    e_step  = 1'b1;
                    m_steps = (m_steps + 1) % 256;
                end
            end
        end
        e_busy = m_busy;
    endtask

    task automatic clk_step();
        model_update();
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("clear", 32'(bus.Clear), 32'(e_clear));
            chk("sel",   32'({bus.S1, bus.S0}), 32'(e_sel));
            chk("right", 32'(bus.Right), 32'(e_right));
            chk("left",  32'(bus.Left), 32'(e_left));
            chk("par",   32'({bus.D, bus.C, bus.B, bus.A}), 32'(e_par));
            chk("step",  32'(bus.STEP), 32'(e_step));
            chk("fix",   32'(bus.FIX), 32'(e_fix));
            chk("steps", 32'(bus.STEPS), 32'(m_steps));
            chk("busy",  32'(bus.BUSY), 32'(e_busy));
        end
    endtask

    task automatic wait_steps(input int n);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 60) begin
            clk_step();
            cyc++;
            if (bus.STEP) seen++;
        end
        chk("step_timeout", 32'(seen), 32'(n));
    endtask

    // START pulse, CLR, LOAD, then the first RUN cycle with the loaded Q visible.
    task automatic do_start();
        bus.START = 1'b1;
        clk_step();
        bus.START = 1'b0;
        chk("start_clear", 32'(bus.Clear), 32'd0);
        clk_step();
        chk("start_load_step", 32'(bus.STEP), 32'd1);
        chk("start_load_sel", 32'({bus.S1, bus.S0}), 32'd3);
        clk_step();
    endtask

    initial begin
        int stop_steps;
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        bus.EN    = 1'b1;
        bus.MODE  = 2'd0;
        bus.SEED  = 4'd0;

        rst = 1'b1;
        clk_step();
        clk_step();
        rst = 1'b0;
        chk("rst_clear", 32'(bus.Clear), 32'd1);
        chk("rst_sel", 32'({bus.S1, bus.S0}), 32'd0);
        chk("rst_steps", 32'(bus.STEPS), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        clk_step();

        // Ring right from 0001
        bus.SEED = 4'b0001;
        bus.START = 1'b1;
        clk_step();
        bus.START = 1'b0;
        chk("ring_clr", 32'(bus.Clear), 32'd0);
        clk_step();
        chk("ring_load_step", 32'(bus.STEP), 32'd1);
        chk("ring_load_par", 32'({bus.D, bus.C, bus.B, bus.A}), 32'd1);
        clk_step();
        chk("ring_q0", 32'(bus.Q), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_steps(1);
            chk("ring_sel", 32'({bus.S1, bus.S0}), 32'd1);
            clk_step();
            chk("ring_q", 32'(bus.Q), 32'(ring_exp[i]));
        end
        chk("ring_steps5", 32'(bus.STEPS), 32'd5);

        // Johnson with an illegal seed
        bus.STOP = 1'b1;
        clk_step();
        bus.STOP = 1'b0;
        bus.MODE = 2'd2;
        bus.SEED = 4'b0101;
        do_start();
        chk("john_q0", 32'(bus.Q), 32'd0);
        for (int i = 0; i < 8; i++) begin
            wait_steps(1);
            clk_step();
            chk("john_q", 32'(bus.Q), 32'(john_exp[i]));
        end

        // Illegal Q in ring mode gets reloaded
        bus.STOP = 1'b1;
        clk_step();
        bus.STOP = 1'b0;
        bus.MODE = 2'd0;
        bus.SEED = 4'b0100;
        do_start();
        chk("fix_q0", 32'(bus.Q), 32'b0100);
        ovr_val = 4'b0110;
        ovr = 1'b1;
        wait_steps(1);
        chk("fix_flag", 32'(bus.FIX), 32'd1);
        chk("fix_sel", 32'({bus.S1, bus.S0}), 32'd3);
        chk("fix_par", 32'({bus.D, bus.C, bus.B, bus.A}), 32'b0100);
        clk_step();
        ovr = 1'b0;
        wait_steps(1);
        chk("fix_after_flag", 32'(bus.FIX), 32'd0);
        chk("fix_after_sel", 32'({bus.S1, bus.S0}), 32'd1);
        clk_step();
        chk("fix_after_q", 32'(bus.Q), 32'b1000);

        // EN pause with prescaler at 2
        wait_steps(1);
        clk_step();
        clk_step();
        bus.EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_step();
            chk("pause_step", 32'(bus.STEP), 32'd0);
        end
        bus.EN = 1'b1;
        clk_step();
        chk("resume_step1", 32'(bus.STEP), 32'd0);
        clk_step();
        chk("resume_step2", 32'(bus.STEP), 32'd1);

        // STOP on the tick edge together with START
        clk_step();
        clk_step();
        clk_step();
        stop_steps = m_steps;
        bus.STOP = 1'b1;
        bus.START = 1'b1;
        clk_step();
        bus.STOP = 1'b0;
        bus.START = 1'b0;
        chk("stop_step", 32'(bus.STEP), 32'd0);
        chk("stop_busy", 32'(bus.BUSY), 32'd0);
        chk("stop_sel", 32'({bus.S1, bus.S0}), 32'd0);
        chk("stop_steps", 32'(bus.STEPS), 32'(stop_steps));

        // RST during RUN, then a fresh start
        bus.SEED = 4'b0001;
        do_start();
        wait_steps(2);
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        chk("rstrun_steps", 32'(bus.STEPS), 32'd0);
        chk("rstrun_busy", 32'(bus.BUSY), 32'd0);
        chk("rstrun_step", 32'(bus.STEP), 32'd0);
        do_start();
        chk("restart_steps", 32'(bus.STEPS), 32'd1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            bus.START = ($urandom % 20 == 0);
            bus.STOP  = ($urandom % 40 == 0);
            bus.EN    = ($urandom % 5 != 0);
            if ($urandom % 30 == 0) begin
                bus.MODE = 2'($urandom_range(3));
                bus.SEED = 4'($urandom_range(15));
            end
            ovr     = ($urandom % 25 == 0);
            ovr_val = 4'($urandom_range(15));
            rst     = ($urandom % 200 == 0);
            clk_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sreg194_seq_ctrl.md
Name: sreg194_seq_ctrl

Overview:
Sequencer/configurator for the team's 74LS194-style 4-bit universal shift register in the ring-counter display path. It replaces the derived slow clock with a one-cycle STEP strobe. The 194 model is clocked by exCLK and uses STEP as its clock enable. The block generates mode pins (Clear, S1, S0), serial inputs (Left, Right) and parallel data (A–D); it runs ring-right, ring-left or Johnson sequences with self-start correction.

Parameters:
DIV, 27000000, exCLK cycles per shift tick while running (min 2)
CW, 25, prescaler width; must satisfy 2^CW >= DIV

Ports:
exCLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous reset, active-high
START  input  1  one-cycle pulse; begins clear/load/run from IDLE
STOP  input  1  one-cycle pulse; returns to IDLE from any state
EN  input  1  run enable; low freezes the prescaler in RUN (pause)
MODE  input  2  00 ring right, 01 ring left, 10 Johnson right, 11 hold
SEED  input  4  load pattern, SEED[0]=A ... SEED[3]=D
Q  input  4  register outputs fed back, Q[0]=QA ... Q[3]=QD
Clear  output  1  active-low clear to register
S1, S0  output  1 each  194 mode select (00 hold, 01 right, 10 left, 11 load)
Right, Left  output  1 each  serial inputs
A, B, C, D  output  1 each  parallel load data
STEP  output  1  register clock enable, one exCLK cycle wide
FIX  output  1  pulses with STEP when an illegal state is reloaded
STEPS  output  8  count of STEP pulses since START; wraps 255->0
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, Clear=1, S1S0=00, Right=Left=0, A..D=0, STEP=0, FIX=0, STEPS=0, BUSY=0, prescaler=0.
- All outputs are registered. Register controls are valid in the same cycle STEP=1.
- IDLE: S1S0=00, STEP=0. START and not STOP -> CLR. START while BUSY is ignored.
- CLR (1 cycle): Clear=0, STEP=0, STEPS<=0 -> LOAD.
- LOAD (1 cycle): S1S0=11, A..D=load value, STEP=1 -> RUN, prescaler<=0.
- Load value:
  - Ring modes: SEED if exactly one bit is set, else 4'b0001 (QA=1).
  - Johnson: SEED if it is a legal Johnson state, else 0000.
  - Hold: SEED unchanged.
- Legal Johnson states (QA..QD): 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- RUN: the prescaler increments only while EN=1. tick = (prescaler==DIV-1 and EN). On tick the prescaler goes to 0. While EN=0 the prescaler holds its value (not cleared).
- On tick, mode is sampled:
  - 00: if Q is one-hot, S1S0=01, Right=Q[3].
  - 01: if Q is one-hot, S1S0=10, Left=Q[0].
  - 10: if Q is a legal Johnson state, S1S0=01, Right=~Q[3].
  - 11: S1S0=00, STEP=0, STEPS unchanged.
  - Illegal Q for the current mode (including right after a mode change): S1S0=11, A..D=load value, FIX=1.
  - Every tick except mode 11 asserts STEP=1 and increments STEPS.
- Non-tick cycles: STEP=0, FIX=0, S1S0=00.
- STOP in any state -> IDLE next cycle with reset output values, except STEPS, which holds. STOP beats a simultaneous START or tick.
- RST mid-operation -> full reset values next cycle, with no STEP issued.

Test Plan:
- DIV=4, SEED=0001, MODE=00, EN=1, START:
  - Response: CLR 1 cycle; LOAD with STEP, S1S0=11, A..D=0001; then STEP every 4 cycles with S1S0=01 and Right=Q[3].
  - With a 194 model, Q goes 0001->0010->0100->1000->0001; STEPS=5 after the 4th shift (LOAD plus 4 shifts).
- MODE=10, SEED=0101 (illegal):
  - Response: load 0000; Q cycles through the 8 Johnson states; Q=0000 again after 8 shift STEPs.
- In RUN ring mode, force Q=0110:
  - Response: next tick gives STEP=1, FIX=1, S1S0=11, A..D=SEED (or 0001); the following tick shifts normally with FIX=0.
- EN low for 10 cycles at prescaler=2, then high:
  - Response: no STEP while EN=0; STEP exactly 2 cycles after EN returns high.
- STOP coincident with a tick and with START:
  - Response: STEP=0, state IDLE, S1S0=00, BUSY=0, STEPS holds its value.
- RST during RUN:
  - Response: next cycle all outputs at reset values, STEPS=0, BUSY=0.
  - A subsequent START repeats the CLR/LOAD sequence.
